swi_debouncer: RTL and testbench

//  Input-side conditioner for the board switch bank. It is the read direction of the

---
 rtl/swi_debouncer.sv | 84 ++++++++
 tb/tb_swi_debouncer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/swi_debouncer.sv
// Switch-bank conditioner: 2-flop sync, per-bit debounce, edge pulses.
// Optional toggle latch per bit enabled by defining DEBOUNCE_TOGGLE_EN.
module swi_debouncer #(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] SWI,
    output logic [NBITS-1:0] stable,
    output logic [NBITS-1:0] rise,
    output logic [NBITS-1:0] fall,
    output logic [NBITS-1:0] toggle
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] r_sync1;
    logic [NBITS-1:0] r_sync2;
    logic [NBITS-1:0] r_stable;
    logic [NBITS-1:0] r_rise;
    logic [NBITS-1:0] r_fall;
    logic [CW-1:0]    r_cnt [NBITS];

    logic [NBITS-1:0] w_dev;
    logic [NBITS-1:0] w_done;

    always_comb begin
        w_dev  = r_sync2 ^ r_stable;
        w_done = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_done[i] = w_dev[i] && (r_cnt[i] == LAST);
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            for (int i = 0; i < NBITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= SWI;
            r_sync2  <= r_sync1;
            r_stable <= r_stable ^ w_done;
            r_rise   <= w_done & r_sync2;
            r_fall   <= w_done & ~r_sync2;
            // Any return to the stable level, or an accepted change, restarts the count.
            for (int i = 0; i < NBITS; i++) begin
                if (w_dev[i] && !w_done[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef DEBOUNCE_TOGGLE_EN
    logic [NBITS-1:0] r_toggle;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_toggle <= '0;
        end else begin
            r_toggle <= r_toggle ^ (w_done & r_sync2);
        end
    end

    assign toggle = r_toggle;
`else
    assign toggle = '0;
`endif

    assign stable = r_stable;
    assign rise   = r_rise;
    assign fall   = r_fall;

endmodule

// File: tb/tb_swi_debouncer.sv
// Scoreboard bench for swi_debouncer: window-based reference model,
// directed scenarios followed by randomized switch activity.
module tb_swi_debouncer;

    localparam int NBITS = 8;
    localparam int D     = 4;

    logic             clk_2;
    logic             reset;
    logic [NBITS-1:0] SWI;
    logic [NBITS-1:0] stable;
    logic [NBITS-1:0] rise;
    logic [NBITS-1:0] fall;
    logic [NBITS-1:0] toggle;

    int total;
    int bad;

    swi_debouncer #(
        .NBITS           (NBITS),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_2  (clk_2),
        .reset  (reset),
        .SWI    (SWI),
        .stable (stable),
        .rise   (rise),
        .fall   (fall),
        .toggle (toggle)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    typedef struct packed {
        logic [NBITS-1:0] st;
        logic [NBITS-1:0] ri;
        logic [NBITS-1:0] fa;
        logic [NBITS-1:0] tg;
    } exp_t;

    exp_t exp_q [$];

    // Reference: a bit's level is accepted once the synchronised input
    // (SWI seen two edges earlier) has disagreed with it for D edges in a row.
    logic [NBITS-1:0] hist [0:D];
    logic [NBITS-1:0] m_stable;
    logic [NBITS-1:0] m_tog;

    always @(posedge clk_2) begin
        logic [NBITS-1:0] mask;
        logic [NBITS-1:0] r;
        logic [NBITS-1:0] f;
        exp_t e;
        if (reset) begin
            for (int j = 0; j <= D; j++) hist[j] = '0;
            m_stable = '0;
            m_tog    = '0;
            r = '0;
            f = '0;
        end else begin
            mask = '1;
            for (int j = 1; j <= D; j++) mask &= hist[j] ^ m_stable;
            r = mask & ~m_stable;
            f = mask & m_stable;
            m_stable = m_stable ^ mask;
`ifdef DEBOUNCE_TOGGLE_EN
            m_tog = m_tog ^ r;
`endif
            for (int j = D; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = SWI;
        end
        e.st = m_stable;
        e.ri = r;
        e.fa = f;
        e.tg = m_tog;
        exp_q.push_back(e);
    end

    always @(negedge clk_2) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (stable !== e.st || rise !== e.ri || fall !== e.fa || toggle !== e.tg) begin
                bad++;
                $display("FAIL outputs t=%0t got st=%h ri=%h fa=%h tg=%h want st=%h ri=%h fa=%h tg=%h",
                         $time, stable, rise, fall, toggle, e.st, e.ri, e.fa, e.tg);
            end
        end else if (total > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard t=%0t got empty queue want one entry", $time);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    initial begin
        int hold;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        SWI   = 8'hFF;
        for (int j = 0; j <= D; j++) hist[j] = '0;
        m_stable = '0;
        m_tog    = '0;
        cyc(2);
        reset = 1'b0;
        cyc(12);

        SWI = 8'h00;
        cyc(12);
        SWI[0] = 1'b1;
        cyc(10);
        SWI[0] = 1'b0;
        cyc(10);

        SWI[3] = 1'b1;
        cyc(3);
        SWI[3] = 1'b0;
        cyc(8);
        for (int k = 0; k < 20; k++) begin
            SWI[3] = ~SWI[3];
            cyc(2);
        end
        SWI[3] = 1'b0;
        cyc(8);

        SWI = 8'hA5;
        cyc(10);
        SWI = 8'h5A;
        cyc(10);
        SWI = 8'h00;
        cyc(10);

        SWI[1] = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(12);
        SWI = 8'h00;
        cyc(10);

        for (int k = 0; k < 3; k++) begin
            SWI[2] = 1'b1;
            cyc(8);
            SWI[2] = 1'b0;
            cyc(8);
        end

        SWI = 8'h00;
        cyc(1);
        SWI = 8'hFF;
        cyc(D + 1);
        SWI = 8'h00;
        cyc(10);

        for (int k = 0; k < 400; k++) begin
            SWI  = SWI ^ NBITS'($urandom & $urandom);
            hold = $urandom_range(1, 2 * D + 2);
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
                hold = hold > 1 ? hold - 1 : 1;
            end
            cyc(hold);
        end
        cyc(12);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
